// File: rtl/dot_row_feeder_pkg.sv
// Shared constants and the packed row record for the 28-lane dot-product row feeder.
package dot_feeder_pkg;
    localparam int PIXEL_N     = 28;
    localparam int PIXEL_SIZE  = 10;
    localparam int WEIGHT_SIZE = 19;
    localparam int ACC_SIZE    = 26;
    localparam int IDX_W       = 5;

    typedef logic [PIXEL_N-1:0][PIXEL_SIZE-1:0]  pix_row_t;
    typedef logic [PIXEL_N-1:0][WEIGHT_SIZE-1:0] wgt_row_t;

    typedef struct packed {
        pix_row_t               pixels;
        wgt_row_t               weights;
        logic [WEIGHT_SIZE-1:0] bias;
        logic [IDX_W-1:0]       idx;
        logic                   last;
    } row_t;
endpackage

// File: rtl/dot_row_feeder_if.sv
// Pair-stream input and row output bundle of the feeder; in_last exists only
// when FEEDER_SHORT_FRAME_EN is defined.
interface dot_row_feeder_if;
    import dot_feeder_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [PIXEL_SIZE-1:0]          in_pixel;
    logic [WEIGHT_SIZE-1:0]         in_weight;
    logic [WEIGHT_SIZE-1:0]         in_bias;
`ifdef FEEDER_SHORT_FRAME_EN
    logic                           in_last;
`endif
    logic                           row_valid;
    logic                           row_ready;
    logic [PIXEL_N*PIXEL_SIZE-1:0]  PixelRow;
    logic [PIXEL_N*WEIGHT_SIZE-1:0] WeightRow;
    logic [WEIGHT_SIZE-1:0]         WeightBias;
    logic [IDX_W-1:0]               row_idx;
    logic                           row_first;
    logic                           row_last;

    modport master (
        input  in_valid, in_pixel, in_weight, in_bias,
`ifdef FEEDER_SHORT_FRAME_EN
        input  in_last,
`endif
        input  row_ready,
        output in_ready, row_valid, PixelRow, WeightRow, WeightBias,
        output row_idx, row_first, row_last
    );

    modport slave (
        output in_valid, in_pixel, in_weight, in_bias,
`ifdef FEEDER_SHORT_FRAME_EN
        output in_last,
`endif
        output row_ready,
        input  in_ready, row_valid, PixelRow, WeightRow, WeightBias,
        input  row_idx, row_first, row_last
    );
endinterface

// File: rtl/dot_row_feeder_row_buf.sv
// One 28-lane row register: per-lane write, optional zero-fill of the lanes above
// the written one, full flag and row tags (bias, index, last).
module feeder_row_buf
    import dot_feeder_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       lane_i,
    input  logic [PIXEL_SIZE-1:0]  pixel_i,
    input  logic [WEIGHT_SIZE-1:0] weight_i,
    input  logic                   bias_en_i,
    input  logic [WEIGHT_SIZE-1:0] bias_i,
    input  logic                   zero_fill_i,
    input  logic                   complete_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic                   last_i,
    input  logic                   release_i,
    output logic                   full_o,
    output row_t                   row_o
);
    pix_row_t               pix_q;
    wgt_row_t               wgt_q;
    logic [WEIGHT_SIZE-1:0] bias_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   last_q;
    logic                   full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q  <= '0;
            wgt_q  <= '0;
            bias_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            for (int k = 0; k < PIXEL_N; k++) begin
                if (wr_en_i && lane_i == IDX_W'(k)) begin
                    pix_q[k] <= pixel_i;
                    wgt_q[k] <= weight_i;
                end else if (wr_en_i && zero_fill_i && IDX_W'(k) > lane_i) begin
                    // early row end: stale lanes from the previous use must not leak out
                    pix_q[k] <= '0;
                    wgt_q[k] <= '0;
                end
            end
            if (wr_en_i && bias_en_i)
                bias_q <= bias_i;
            if (complete_i) begin
                full_q <= 1'b1;
                idx_q  <= idx_i;
                last_q <= last_i;
            end else if (release_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign full_o        = full_q;
    assign row_o.pixels  = pix_q;
    assign row_o.weights = wgt_q;
    assign row_o.bias    = bias_q;
    assign row_o.idx     = idx_q;
    assign row_o.last    = last_q;
endmodule

// File: rtl/dot_row_feeder.sv
// Ping-pong row feeder: packs (pixel, weight) beats into 28-lane rows for the dot engine.
// Optional FEEDER_SHORT_FRAME_EN adds in_last for early row/frame termination.
module dot_row_feeder
    import dot_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              GlobalReset,
    dot_row_feeder_if.master  bus
);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(PIXEL_N - 1);

    logic                   fill_ptr_q, fill_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]       col_q, col_d;
    logic [IDX_W-1:0]       frow_q, frow_d;
    logic [WEIGHT_SIZE-1:0] fbias_q, fbias_d;

    logic [1:0]             full;
    row_t                   rows [2];
    row_t                   rd_row;
    logic                   accept, complete, frame_end, zero_fill, rel, first_beat, row_valid;
    logic [WEIGHT_SIZE-1:0] bias_val;

    assign bus.in_ready = ~full[fill_ptr_q];
    assign accept       = bus.in_valid & ~full[fill_ptr_q];
    assign row_valid    = full[rd_ptr_q];
    assign rel          = row_valid & bus.row_ready;
    assign first_beat   = (col_q == '0) && (frow_q == '0);
    // rows 1..27 inherit the bias captured on the frame's first beat
    assign bias_val     = first_beat ? bus.in_bias : fbias_q;

`ifdef FEEDER_SHORT_FRAME_EN
    assign zero_fill = bus.in_last;
    assign complete  = accept & ((col_q == LAST_LANE) | bus.in_last);
    assign frame_end = (frow_q == LAST_LANE) | bus.in_last;
`else
    assign zero_fill = 1'b0;
    assign complete  = accept & (col_q == LAST_LANE);
    assign frame_end = (frow_q == LAST_LANE);
`endif

    always_comb begin
        col_d      = col_q;
        frow_d     = frow_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fbias_d    = fbias_q;
        if (accept && first_beat)
            fbias_d = bus.in_bias;
        if (complete) begin
            col_d      = '0;
            fill_ptr_d = ~fill_ptr_q;
            frow_d     = frame_end ? '0 : frow_q + IDX_W'(1);
        end else if (accept) begin
            col_d = col_q + IDX_W'(1);
        end
        if (rel)
            rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            fill_ptr_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            col_q      <= '0;
            frow_q     <= '0;
            fbias_q    <= '0;
        end else begin
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            col_q      <= col_d;
            frow_q     <= frow_d;
            fbias_q    <= fbias_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        feeder_row_buf u_buf (
            .clk_i       (clk),
            .rst_ni      (GlobalReset),
            .wr_en_i     (accept && (fill_ptr_q == 1'(b))),
            .lane_i      (col_q),
            .pixel_i     (bus.in_pixel),
            .weight_i    (bus.in_weight),
            .bias_en_i   (col_q == '0),
            .bias_i      (bias_val),
            .zero_fill_i (zero_fill),
            .complete_i  (complete && (fill_ptr_q == 1'(b))),
            .idx_i       (frow_q),
            .last_i      (frame_end),
            .release_i   (rel && (rd_ptr_q == 1'(b))),
            .full_o      (full[b]),
            .row_o       (rows[b])
        );
    end

    assign rd_row         = rows[rd_ptr_q];
    assign bus.row_valid  = row_valid;
    assign bus.PixelRow   = rd_row.pixels;
    assign bus.WeightRow  = rd_row.weights;
    assign bus.WeightBias = rd_row.bias;
    assign bus.row_idx    = rd_row.idx;
    assign bus.row_first  = row_valid & (rd_row.idx == '0);
    assign bus.row_last   = row_valid & rd_row.last;
endmodule

// File: tb/tb_dot_row_feeder.sv
// Directed bench for dot_row_feeder: basic row, full frame/throughput, backpressure,
// async reset and (with FEEDER_SHORT_FRAME_EN) short rows.
`timescale 1ns/1ps
module tb_dot_row_feeder;
    import dot_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_row_feeder_if bus();
    dot_row_feeder u_dut (.clk(clk), .GlobalReset(rst_n), .bus(bus));

    int          n_chk = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { row_t r; logic first; int unsigned t; } rec_t;
    rec_t rec_q[$];

    function automatic row_t bus_row();
        row_t r;
        r.pixels  = bus.PixelRow;
        r.weights = bus.WeightRow;
        r.bias    = bus.WeightBias;
        r.idx     = bus.row_idx;
        r.last    = bus.row_last;
        return r;
    endfunction

    // record every row handed over (transfer happens on the following posedge)
    always @(negedge clk) begin : mon
        rec_t x;
        if (rst_n && bus.row_valid && bus.row_ready) begin
            x.r     = bus_row();
            x.first = bus.row_first;
            x.t     = cyc;
            rec_q.push_back(x);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PIXEL_SIZE-1:0] fpix(int n);
        return PIXEL_SIZE'(n);
    endfunction
    function automatic logic [WEIGHT_SIZE-1:0] fwgt(int n);
        return WEIGHT_SIZE'(n * 7 - 3000);
    endfunction

    // lanes below n carry beats base.., lanes from n up must be zero
    function automatic int lane_errs(row_t r, int base, int n);
        int e = 0;
        for (int k = 0; k < PIXEL_N; k++) begin
            if (k < n) begin
                if (r.pixels[k] !== fpix(base + k)) e++;
                if (r.weights[k] !== fwgt(base + k)) e++;
            end else begin
                if (r.pixels[k] !== '0) e++;
                if (r.weights[k] !== '0) e++;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [PIXEL_SIZE-1:0] p, input logic [WEIGHT_SIZE-1:0] w,
                        input logic [WEIGHT_SIZE-1:0] b);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_pixel  = p;
        bus.in_weight = w;
        bus.in_bias   = b;
        while (!bus.in_ready && n < 100) begin tick(); n++; end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        tick();
    endtask

`ifdef FEEDER_SHORT_FRAME_EN
    task automatic send_last(input logic [PIXEL_SIZE-1:0] p, input logic [WEIGHT_SIZE-1:0] w,
                             input logic [WEIGHT_SIZE-1:0] b);
        bus.in_last = 1'b1;
        send(p, w, b);
        bus.in_last = 1'b0;
    endtask
`endif

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.row_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rec_q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        int unsigned t0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_weight = '0;
        bus.in_bias   = '0;
        bus.row_ready = 1'b0;
`ifdef FEEDER_SHORT_FRAME_EN
        bus.in_last   = 1'b0;
`endif
        do_reset();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_row_valid", bus.row_valid, 0);
        chk("rst_pix_zero", |bus.PixelRow, 0);
        chk("rst_wgt_zero", |bus.WeightRow, 0);
        chk("rst_bias", bus.WeightBias, 0);
        chk("rst_idx", bus.row_idx, 0);

        // basic row: pixel=k, weight=k+100
        bus.row_ready = 1'b1;
        for (int k = 0; k < PIXEL_N - 1; k++) send(PIXEL_SIZE'(k), WEIGHT_SIZE'(k + 100), '0);
        chk("basic_valid_early", bus.row_valid, 0);
        send(PIXEL_SIZE'(27), WEIGHT_SIZE'(127), '0);
        chk("basic_valid", bus.row_valid, 1);
        e = 0;
        for (int k = 0; k < PIXEL_N; k++) begin
            if (bus.PixelRow[k*PIXEL_SIZE +: PIXEL_SIZE] !== PIXEL_SIZE'(k)) e++;
            if (bus.WeightRow[k*WEIGHT_SIZE +: WEIGHT_SIZE] !== WEIGHT_SIZE'(k + 100)) e++;
        end
        chk("basic_lanes", e, 0);
        chk("basic_idx", bus.row_idx, 0);
        chk("basic_first", bus.row_first, 1);
        chk("basic_last", bus.row_last, 0);
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("basic_released", bus.row_valid, 0);

        // full frame, back-to-back with row_ready held high
        do_reset();
        bus.row_ready = 1'b1;
        t0 = cyc;
        for (int n = 0; n < PIXEL_N * PIXEL_N; n++)
            send(fpix(n), fwgt(n), (n == 0) ? 19'h7FF00 : WEIGHT_SIZE'(n * 13));
        chk("frame_beat_cycles", cyc - t0, 784);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("frame_rows", rec_q.size(), 28);
        for (int r = 0; r < PIXEL_N && r < rec_q.size(); r++) begin
            chk($sformatf("frame_idx_%0d", r), rec_q[r].r.idx, r);
            chk($sformatf("frame_bias_%0d", r), rec_q[r].r.bias, 19'h7FF00);
            chk($sformatf("frame_first_%0d", r), rec_q[r].first, (r == 0));
            chk($sformatf("frame_last_%0d", r), rec_q[r].r.last, (r == 27));
            chk($sformatf("frame_lanes_%0d", r), lane_errs(rec_q[r].r, r * PIXEL_N, PIXEL_N), 0);
        end
        if (rec_q.size() >= 28) chk("frame_last_release", rec_q[27].t - t0, 784);

        // backpressure: two rows held, third stalls
        do_reset();
        for (int n = 0; n < 56; n++) send(fpix(n), fwgt(n), 19'h01234);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_row_valid", bus.row_valid, 1);
        bus.in_valid  = 1'b1;
        bus.in_pixel  = fpix(56);
        bus.in_weight = fwgt(56);
        repeat (3) tick();
        chk("bp_stall", bus.in_ready, 0);
        chk("bp_row0_idx", bus.row_idx, 0);
        chk("bp_row0_lanes", lane_errs(bus_row(), 0, PIXEL_N), 0);
        chk("bp_row0_bias", bus.WeightBias, 19'h01234);
        bus.row_ready = 1'b1;
        tick();
        bus.row_ready = 1'b0;
        chk("bp_ready_back", bus.in_ready, 1);
        chk("bp_row1_idx", bus.row_idx, 1);
        tick();
        for (int n = 57; n < 60; n++) send(fpix(n), fwgt(n), '0);
        bus.in_valid = 1'b0;
        chk("bp_row1_lanes", lane_errs(bus_row(), 28, PIXEL_N), 0);
        bus.row_ready = 1'b1;
        tick();
        bus.row_ready = 1'b0;
        chk("bp_empty_head", bus.row_valid, 0);
        for (int n = 60; n < 84; n++) send(fpix(n), fwgt(n), '0);
        bus.in_valid = 1'b0;
        chk("bp_row2_idx", bus.row_idx, 2);
        chk("bp_row2_lanes", lane_errs(bus_row(), 56, PIXEL_N), 0);

        // async reset mid-frame
        do_reset();
        bus.row_ready = 1'b1;
        for (int n = 0; n < 300; n++) send(fpix(n), fwgt(n), 19'h11111);
        chk("ar_pre_nonzero", |bus.PixelRow, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pix_zero", |bus.PixelRow, 0);
        chk("ar_wgt_zero", |bus.WeightRow, 0);
        chk("ar_bias_zero", bus.WeightBias, 0);
        chk("ar_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        rec_q.delete();
        send(PIXEL_SIZE'(5), 19'h00777, 19'h00ABC);
        for (int k = 1; k < PIXEL_N; k++) send(PIXEL_SIZE'(k + 40), WEIGHT_SIZE'(k), '0);
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("ar_rows", rec_q.size(), 1);
        if (rec_q.size() > 0) begin
            chk("ar_lane0_pix", rec_q[0].r.pixels[0], 5);
            chk("ar_lane0_wgt", rec_q[0].r.weights[0], 19'h00777);
            chk("ar_bias", rec_q[0].r.bias, 19'h00ABC);
            chk("ar_idx", rec_q[0].r.idx, 0);
            chk("ar_first", rec_q[0].first, 1);
        end

`ifdef FEEDER_SHORT_FRAME_EN
        // two full rows leave stale data in both buffers, then two short rows
        do_reset();
        bus.row_ready = 1'b1;
        for (int n = 0; n < 56; n++) send(fpix(n), fwgt(n), 19'h05555);
        for (int n = 56; n < 65; n++) send(fpix(n), fwgt(n), '0);
        send_last(fpix(65), fwgt(65), '0);
        send(fpix(66), fwgt(66), 19'h2AAAA);
        for (int n = 67; n < 75; n++) send(fpix(n), fwgt(n), '0);
        send_last(fpix(75), fwgt(75), '0);
        for (int n = 76; n < 104; n++) send(fpix(n), fwgt(n), '0);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("sf_rows", rec_q.size(), 5);
        if (rec_q.size() >= 5) begin
            chk("sf_r2_idx", rec_q[2].r.idx, 2);
            chk("sf_r2_last", rec_q[2].r.last, 1);
            chk("sf_r2_lanes", lane_errs(rec_q[2].r, 56, 10), 0);
            chk("sf_r3_idx", rec_q[3].r.idx, 0);
            chk("sf_r3_first", rec_q[3].first, 1);
            chk("sf_r3_last", rec_q[3].r.last, 1);
            chk("sf_r3_bias", rec_q[3].r.bias, 19'h2AAAA);
            chk("sf_r3_lanes", lane_errs(rec_q[3].r, 66, 10), 0);
            chk("sf_r4_idx", rec_q[4].r.idx, 1);
            chk("sf_r4_last", rec_q[4].r.last, 0);
            chk("sf_r4_lanes", lane_errs(rec_q[4].r, 76, PIXEL_N), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dot_row_feeder.md
Name: dot_row_feeder

Overview:
- Producer side of the 28-lane dot-product row interface.
- Accepts a serial stream of (pixel, weight) pairs, one pair per beat over valid/ready, and assembles them into 28-lane rows.
- Presents the 28 pixels plus 28 weights of one row at a time to the dot-product engine, with a row-level valid/ready handshake and frame framing (28 rows = 784 pairs = one image).
- Ping-pong row buffering lets streaming input continue while the engine consumes the previous row.

Parameters:
- PIXEL_N, 28, lanes per row and rows per frame.
- PIXEL_SIZE, 10, pixel width in bits (unsigned).
- WEIGHT_SIZE, 19, weight width in bits (two's complement).

Ports:
- clk  in  1  system clock; all state on posedge.
- GlobalReset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  feeder can accept the pair this cycle.
- in_pixel  in  PIXEL_SIZE  pixel of current pair.
- in_weight  in  WEIGHT_SIZE  weight of current pair.
- in_bias  in  WEIGHT_SIZE  bias; sampled only on frame's first accepted beat.
- row_valid  out  1  a full row is presented.
- row_ready  in  1  engine consumes presented row.
- PixelRow  out  PIXEL_N*PIXEL_SIZE  lane k at bits [k*PIXEL_SIZE +: PIXEL_SIZE].
- WeightRow  out  PIXEL_N*WEIGHT_SIZE  lane k at bits [k*WEIGHT_SIZE +: WEIGHT_SIZE].
- WeightBias  out  WEIGHT_SIZE  bias of the frame the presented row belongs to.
- row_idx  out  5  row number 0..PIXEL_N-1 within frame.
- row_first  out  1  row_idx==0 on the presented row.
- row_last  out  1  row_idx==PIXEL_N-1 on the presented row.

Behaviour:
- Reset (async assert, sync release): in_ready=1, row_valid=0, all data outputs 0, row_idx=0, both buffers empty, fill pointer=buf0, read pointer=buf0, col=0, fill row=0.
- Accept: beat transfers when in_valid&in_ready. The pair is written to lane col of the fill buffer, then col increments.
- Row completion: the accepted beat with col==PIXEL_N-1 marks the fill buffer full and tags it with the fill row index. col wraps to 0 and the fill pointer toggles.
- Frame wrap: fill row increments on each completion and wraps 27->0.
- Bias: a beat accepted with col==0 and fill row==0 stores in_bias into the fill buffer's bias tag. Rows 1..27 copy that bias tag forward.
- in_ready = the buffer under the fill pointer is not full. Combinational from registered state only; it does not depend on in_valid.
- Output: row_valid=1 while the buffer under the read pointer is full. PixelRow, WeightRow, WeightBias and row_idx are driven from that buffer, registered and stable while row_valid=1 and row_ready=0.
- Row release: row_valid&row_ready frees the buffer and toggles the read pointer.
- Latency: row_valid rises the cycle after the 28th beat of a row is accepted, provided that buffer is at the head.
- Throughput: sustained 1 beat/cycle with row_ready held high; no bubble.
- Simultaneous events: completion into buf X and release of buf Y in the same cycle are both honoured. A buffer freed this cycle may be written the next cycle.
- Full/backpressure: both buffers full -> in_ready=0, and input stalls until a release. Partial row contents are retained during a stall.
- Reset mid-row or mid-frame discards partial rows and full buffers. Next accepted beat is row 0 col 0 of a new frame.
- Output lanes are never modified while their buffer is full.

Optional Feature:
- Macro: FEEDER_SHORT_FRAME_EN.
- Enabled: adds input in_last (1 bit).
  - An accepted beat with in_last=1 and col<PIXEL_N-1 completes the row, zero-filling lanes col+1..27.
  - That row is forced to row_last=1, and the fill row resets to 0.
  - in_last on col==PIXEL_N-1 acts as an early frame end: that row gets row_last=1.
- Disabled: no in_last port. Rows complete only at col==PIXEL_N-1, and frames only after 28 rows.

Decomposition:
- Package dot_feeder_pkg holds:
  - PIXEL_N, PIXEL_SIZE, WEIGHT_SIZE, ACC_SIZE(26) constants;
  - the row index width constant (5);
  - a packed row struct typedef {pixels, weights, bias, idx, last}.
- Sub-module feeder_row_buf: one 28-lane row register with lane write-enable, full flag, and tags. Instantiated twice.
- Ping-pong pointers and counters live in the top level.

Test Plan:
- Basic row: reset, stream pairs k=0..27 with pixel=k and weight=k+100, row_ready=1 -> row_valid rises 1 cycle after beat 27. Lane k carries pixel k and weight k+100; row_idx=0, row_first=1.
- Full frame: 784 beats, bias=19'h7FF00 on beat 0 and other values later -> 28 rows with row_idx 0..27. WeightBias=19'h7FF00 on all 28 rows; row_last only on row 27.
- Backpressure: row_ready=0, stream 60 beats -> in_ready drops after beat 55 (2 rows held). Row 0 is unchanged; pulsing row_ready once releases row 0, and in_ready returns the next cycle.
- Simultaneous: hold row_ready=1 with back-to-back beats -> completion and release in the same cycle, zero bubbles, 28 rows in 784+1 cycles.
- Async reset at beat 300 -> outputs clear immediately, without waiting for a clock edge. Next beat (pixel=5) appears at lane 0 of row 0 with the new in_bias.
- FEEDER_SHORT_FRAME_EN: in_last on beat 9 of row 0 -> row has lanes 10..27 = 0 with row_last=1, and the following row is row_idx=0.
